// File: rtl/quant_table_mult_pkg.sv
// Shared types for the quantizer multiply path: command/response records, the
// info metadata carried alongside each command, and coefficient-table sizing.
package quant_table_mult_pkg;

  typedef enum logic {
    ModeEncode = 1'b0,
    ModeDecode = 1'b1
  } quant_mode_e;

  // 77-bit metadata echoed unchanged from command to response.
  typedef struct packed {
    quant_mode_e mode;
    logic [31:0] samplecount;
    logic [5:0]  buf_idx;
    logic [5:0]  ch_id;
    logic [31:0] frame_id;
  } packed_intea_info_t;

  localparam int unsigned QTM_LATENCY   = 3;
  localparam int unsigned QTM_TBL_DEPTH = 16;
  localparam int unsigned QTM_IDX_W     = $clog2(QTM_TBL_DEPTH);

  typedef logic signed [1:-6]   coef_t;  // -2.0 .. +1.984375
  typedef logic        [-1:-14] scf_t;   // unsigned fraction
  typedef logic signed [1:-20]  prod_t;  // exact coef * scf
  typedef logic [QTM_IDX_W-1:0] tbl_idx_t;

  typedef struct packed {
    logic               req;
    tbl_idx_t           idx;
    scf_t               scf;
    packed_intea_info_t info;
  } packed_mult_cmd_t;

  typedef struct packed {
    logic               ack;
    prod_t              res;
    packed_intea_info_t info;
  } packed_mult_rsp_t;

endpackage

// File: rtl/quant_table_mult_if.sv
// Multiply request/response bus between the quantize stage and the multiplier.
interface quant_table_mult_if
  import quant_table_mult_pkg::*;
();

  packed_mult_cmd_t mult_cmd;
  packed_mult_rsp_t mult_rsp;

  // Quantizer side issues commands and consumes responses.
  modport master (
    output mult_cmd,
    input  mult_rsp
  );

  // Multiplier side.
  modport slave (
    input  mult_cmd,
    output mult_rsp
  );

endinterface

// File: rtl/quant_coef_table.sv
// Programmable coefficient register file: one synchronous write port and one
// combinational read port. A same-edge write is not visible to a read sampled
// on that edge, so lookups see the pre-write value.
module quant_coef_table
  import quant_table_mult_pkg::*;
#(
  parameter int unsigned Depth    = QTM_TBL_DEPTH,
  parameter coef_t       ResetVal = 8'h00,
  localparam int unsigned AddrW   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  coef_t            wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output coef_t            rdata_o
);

  coef_t mem_q [Depth];

  // Entry storage with asynchronous reset to the programmed default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= ResetVal;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/quant_table_mult.sv
// Coefficient-table multiplier: three-stage pipeline returning
// T[idx] * scf exactly, with the command metadata echoed on the response.
// S1 captures the command, S2 the looked-up coefficient, S3 the product.
module quant_table_mult
  import quant_table_mult_pkg::*;
#(
  parameter coef_t TBL_RESET_VAL = 8'h00
) (
  input  logic                clk,
  input  logic                rst_n,
  quant_table_mult_if.slave   mult,
  input  logic                tbl_we_i,
  input  tbl_idx_t            tbl_addr_i,
  input  coef_t               tbl_wdata_i,
  output logic                idle_o
);

  localparam int unsigned LATENCY = QTM_LATENCY;

  // vld_q[0] = S1, vld_q[1] = S2, vld_q[LATENCY-1] = S3 (drives ack).
  logic [LATENCY-1:0] vld_q;

  tbl_idx_t           s1_idx_q;
  scf_t               s1_scf_q;
  packed_intea_info_t s1_info_q;

  coef_t              s2_coef_q;
  scf_t               s2_scf_q;
  packed_intea_info_t s2_info_q;

  prod_t              s3_res_q;
  packed_intea_info_t s3_info_q;

  coef_t              tbl_rdata;
  logic signed [21:0] coef_ext;
  logic signed [21:0] scf_ext;
  prod_t              prod;

  quant_coef_table #(
    .Depth    (QTM_TBL_DEPTH),
    .ResetVal (TBL_RESET_VAL)
  ) u_coef_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (tbl_we_i),
    .waddr_i (tbl_addr_i),
    .wdata_i (tbl_wdata_i),
    .raddr_i (s1_idx_q),
    .rdata_o (tbl_rdata)
  );

  // Stage valid shift register; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], mult.mult_cmd.req};
    end
  end

  // S1: capture command fields only on req so idle-cycle X never enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_idx_q  <= '0;
      s1_scf_q  <= '0;
      s1_info_q <= '0;
    end else if (mult.mult_cmd.req) begin
      s1_idx_q  <= mult.mult_cmd.idx;
      s1_scf_q  <= mult.mult_cmd.scf;
      s1_info_q <= mult.mult_cmd.info;
    end
  end

  // S2: coefficient lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_coef_q <= '0;
      s2_scf_q  <= '0;
      s2_info_q <= '0;
    end else if (vld_q[0]) begin
      s2_coef_q <= tbl_rdata;
      s2_scf_q  <= s1_scf_q;
      s2_info_q <= s1_info_q;
    end
  end

  // Signed x zero-extended unsigned; 22 bits hold every product exactly, so
  // the truncated multiply below is exact.
  always_comb begin
    coef_ext = {{14{s2_coef_q[1]}}, s2_coef_q};
    scf_ext  = {8'b0, s2_scf_q};
    prod     = coef_ext * scf_ext;
  end

  // S3: product and metadata; holds while no new result arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_res_q  <= '0;
      s3_info_q <= '0;
    end else if (vld_q[1]) begin
      s3_res_q  <= prod;
      s3_info_q <= s2_info_q;
    end
  end

  // Response and idle outputs.
  always_comb begin
    mult.mult_rsp.ack  = vld_q[LATENCY-1];
    mult.mult_rsp.res  = s3_res_q;
    mult.mult_rsp.info = s3_info_q;
    idle_o             = ~|vld_q;
  end

endmodule
